// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares one data-memory port between the MEM stage (D)
// and instruction fetch (I). D has priority; a bounded-starvation counter
// forces an I grant after MAX_CONSEC back-to-back D grants while I waits.
// A watchdog completes any grant the memory never acknowledges.
//
// Handshake (both requester sides and the memory side): a requester holds its
// request level until its ack; ack is a single-cycle pulse and the read data
// is valid only in that cycle (zero otherwise). The memory side sees stb/wr_en
// held from registers for the whole grant and answers with a one-cycle ack.
module dmem_port_arbiter #(
  parameter int MAX_CONSEC = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_d_stb,
  input  logic        i_d_wr_en,
  input  logic [31:0] i_d_addr,
  input  logic [31:0] i_d_wr_data,
  output logic        o_d_ack,
  output logic [31:0] o_d_rdata,
  input  logic        i_i_stb,
  input  logic [31:0] i_i_addr,
  output logic        o_i_ack,
  output logic [31:0] o_i_rdata,
  output logic        o_m_stb,
  output logic        o_m_wr_en,
  output logic [31:0] o_m_addr,
  output logic [31:0] o_m_wr_data,
  input  logic        i_m_ack,
  input  logic [31:0] i_m_rdata,
  output logic        o_err,
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_D = 2'd1,
    GNT_I = 2'd2
  } state_e;

  localparam int SW = (MAX_CONSEC < 1) ? 1 : $clog2(MAX_CONSEC + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_CONSEC);
  localparam logic [7:0]    WAIT_LAST  = 8'(TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [7:0]    wait_q, wait_d;
  logic          wr_q, wr_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;

  logic d_req;
  logic i_force;
  logic in_grant;
  logic timeout;
  logic done;

  // Request decode, starvation override and completion conditions.
  always_comb begin
    d_req    = i_d_stb | i_d_wr_en;
    i_force  = i_i_stb && (starve_q == STARVE_MAX);
    in_grant = (state_q != IDLE);
    timeout  = in_grant && !i_m_ack && (wait_q == WAIT_LAST);
    done     = in_grant && (i_m_ack || timeout);
  end

  // Next state: arbitration in IDLE, latch the winner, watchdog in grants.
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    wait_d   = wait_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    case (state_q)
      IDLE: begin
        wait_d = 8'd0;
        if (d_req && !i_force) begin
          state_d = GNT_D;
          wr_d    = i_d_wr_en;
          addr_d  = i_d_addr;
          wdata_d = i_d_wr_data;
          if (!i_i_stb) begin
            starve_d = '0;
          end else if (starve_q != STARVE_MAX) begin
            starve_d = starve_q + SW'(1);
          end
        end else if (i_i_stb) begin
          state_d  = GNT_I;
          wr_d     = 1'b0;
          addr_d   = i_i_addr;
          wdata_d  = 32'd0;
          starve_d = '0;
        end else begin
          starve_d = '0;
        end
      end
      GNT_D, GNT_I: begin
        if (done) begin
          state_d = IDLE;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters and latched request registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      starve_q <= '0;
      wait_q   <= 8'd0;
      wr_q     <= 1'b0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      wait_q   <= wait_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  // Memory drive from latched request; owner ack/rdata straight from memory.
  always_comb begin
    o_m_stb     = 1'b0;
    o_m_wr_en   = 1'b0;
    o_m_addr    = 32'd0;
    o_m_wr_data = 32'd0;
    o_d_ack     = 1'b0;
    o_i_ack     = 1'b0;
    o_d_rdata   = 32'd0;
    o_i_rdata   = 32'd0;
    o_err       = timeout;
    if (state_q == GNT_D) begin
      o_m_stb     = !wr_q;
      o_m_wr_en   = wr_q;
      o_m_addr    = addr_q;
      o_m_wr_data = wdata_q;
      o_d_ack     = done;
      o_d_rdata   = i_m_ack ? i_m_rdata : 32'd0;
    end else if (state_q == GNT_I) begin
      o_m_stb     = 1'b1;
      o_m_addr    = addr_q;
      o_i_ack     = done;
      o_i_rdata   = i_m_ack ? i_m_rdata : 32'd0;
    end
  end

  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: random requesters and a random-latency memory,
// checked every cycle against a transaction-level reference model.
module tb_dmem_port_arbiter;
  localparam int MAX_CONSEC = 4;
  localparam int TIMEOUT    = 16;

  // clock / reset and DUT signals
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_d_stb = 1'b0, i_d_wr_en = 1'b0;
  logic [31:0] i_d_addr = '0, i_d_wr_data = '0;
  logic        o_d_ack;
  logic [31:0] o_d_rdata;
  logic        i_i_stb = 1'b0;
  logic [31:0] i_i_addr = '0;
  logic        o_i_ack;
  logic [31:0] o_i_rdata;
  logic        o_m_stb, o_m_wr_en;
  logic [31:0] o_m_addr, o_m_wr_data;
  logic        i_m_ack = 1'b0;
  logic [31:0] i_m_rdata = '0;
  logic        o_err;
  logic [1:0]  o_dbg_state;

  always #5 clk = ~clk;

  dmem_port_arbiter #(.MAX_CONSEC(MAX_CONSEC), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_d_stb(i_d_stb), .i_d_wr_en(i_d_wr_en), .i_d_addr(i_d_addr),
    .i_d_wr_data(i_d_wr_data), .o_d_ack(o_d_ack), .o_d_rdata(o_d_rdata),
    .i_i_stb(i_i_stb), .i_i_addr(i_i_addr), .o_i_ack(o_i_ack), .o_i_rdata(o_i_rdata),
    .o_m_stb(o_m_stb), .o_m_wr_en(o_m_wr_en), .o_m_addr(o_m_addr),
    .o_m_wr_data(o_m_wr_data), .i_m_ack(i_m_ack), .i_m_rdata(i_m_rdata),
    .o_err(o_err), .o_dbg_state(o_dbg_state)
  );

  int n_checks = 0;
  int n_err    = 0;

  // scoreboard: expected grant owners for the fairness run (1 = I)
  logic [0:0] exp_q[$];

  // reference model: one transaction in flight, plus fairness bookkeeping
  bit          busy, own_i, t_wr;
  logic [31:0] t_addr, t_wdata;
  int          wait_n, lat, starve;
  bit          e_done, e_dack, e_iack, e_err;
  bit          d_act, i_act, fair;

  // stimulus knobs
  int p_d, p_i, lat_lo, lat_hi, p_idle_ack;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask

  // Model update at a rising edge, using the inputs present at that edge.
  task automatic advance();
    bit dr, ir;
    if (busy) begin
      if (e_done) busy = 0;
      else wait_n++;
    end else begin
      dr = i_d_stb | i_d_wr_en;
      ir = i_i_stb;
      if (dr && !(ir && starve == MAX_CONSEC)) begin
        busy = 1; own_i = 0; t_wr = i_d_wr_en;
        t_addr = i_d_addr; t_wdata = i_d_wr_data;
        wait_n = 0; lat = $urandom_range(lat_hi, lat_lo);
        starve = ir ? ((starve < MAX_CONSEC) ? starve + 1 : MAX_CONSEC) : 0;
      end else if (ir) begin
        busy = 1; own_i = 1; t_wr = 0;
        t_addr = i_i_addr; t_wdata = 0;
        wait_n = 0; lat = $urandom_range(lat_hi, lat_lo);
        starve = 0;
      end else begin
        starve = 0;
      end
    end
  endtask

  // Driver: requesters release after their ack and may issue a new request;
  // the memory acks after the planned latency (255 = never).
  task automatic drive();
    int kind;
    if (e_dack) begin d_act = 0; i_d_stb = 0; i_d_wr_en = 0; end
    if (e_iack) begin i_act = 0; i_i_stb = 0; end
    if (!d_act && $urandom_range(99, 0) < p_d) begin
      d_act = 1;
      kind = $urandom_range(2, 0);
      i_d_stb     = (kind != 1);
      i_d_wr_en   = (kind != 0);
      i_d_addr    = $urandom & 32'h7fff_ffff;
      i_d_wr_data = $urandom;
    end
    if (!i_act && $urandom_range(99, 0) < p_i) begin
      i_act = 1;
      i_i_stb  = 1;
      i_i_addr = $urandom | 32'h8000_0000;
    end
    i_m_rdata = $urandom;
    i_m_ack   = busy ? (wait_n == lat) : ($urandom_range(99, 0) < p_idle_ack);
  endtask

  task automatic compare();
    bit last, e_stb, e_wr;
    last   = busy && (wait_n == TIMEOUT - 1);
    e_done = busy && (i_m_ack || last);
    e_err  = busy && !i_m_ack && last;
    e_dack = e_done && !own_i;
    e_iack = e_done && own_i;
    e_stb  = busy && (own_i || !t_wr);
    e_wr   = busy && !own_i && t_wr;
    check("m_stb",   o_m_stb,   e_stb);
    check("m_wr_en", o_m_wr_en, e_wr);
    check("m_addr",  o_m_addr,  busy ? t_addr : 32'd0);
    if (!(busy && !own_i && !t_wr))
      check("m_wr_data", o_m_wr_data, (busy && !own_i) ? t_wdata : 32'd0);
    check("d_ack", o_d_ack, e_dack);
    check("i_ack", o_i_ack, e_iack);
    check("err",   o_err,   e_err);
    if (!(e_dack && t_wr))
      check("d_rdata", o_d_rdata, (e_dack && i_m_ack) ? i_m_rdata : 32'd0);
    check("i_rdata", o_i_rdata, (e_iack && i_m_ack) ? i_m_rdata : 32'd0);
    if (fair && busy && wait_n == 0 && exp_q.size() > 0)
      check("grant_owner", o_m_addr[31], exp_q.pop_front());
  endtask

  task automatic step();
    @(posedge clk);
    advance();
    #1;
    drive();
    #1;
    compare();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic set_knobs(input int pd, input int pi, input int lo, input int hi, input int pia);
    p_d = pd; p_i = pi; lat_lo = lo; lat_hi = hi; p_idle_ack = pia;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_m_stb"},   o_m_stb,     1'b0);
    check({tag, "_m_wr_en"}, o_m_wr_en,   1'b0);
    check({tag, "_m_addr"},  o_m_addr,    32'd0);
    check({tag, "_m_wdata"}, o_m_wr_data, 32'd0);
    check({tag, "_d_ack"},   o_d_ack,     1'b0);
    check({tag, "_i_ack"},   o_i_ack,     1'b0);
    check({tag, "_d_rdata"}, o_d_rdata,   32'd0);
    check({tag, "_i_rdata"}, o_i_rdata,   32'd0);
    check({tag, "_err"},     o_err,       1'b0);
    check({tag, "_state"},   o_dbg_state, 2'd0);
  endtask

  task automatic model_reset();
    busy = 0; own_i = 0; t_wr = 0; t_addr = 0; t_wdata = 0;
    wait_n = 0; lat = 0; starve = 0;
    e_done = 0; e_dack = 0; e_iack = 0; e_err = 0;
  endtask

  initial begin
    int guard;
    model_reset();
    d_act = 0; i_act = 0; fair = 0;
    set_knobs(0, 0, 0, 0, 0);

    // reset state, even with a stray memory ack present
    i_m_ack = 1'b1;
    i_m_rdata = 32'hdead_beef;
    #12;
    check_all_zero("reset");
    i_m_ack = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // fairness: both held, single-cycle memory -> D,D,D,D,I repeating
    for (int k = 0; k < 40; k++) exp_q.push_back(1'((k % 5) == 4));
    fair = 1;
    set_knobs(100, 100, 0, 0, 0);
    run(60);
    check("fair_grants_seen", 32'(exp_q.size() < 25), 32'd1);
    fair = 0;

    // sparse D traffic, short latencies, stray acks while idle
    set_knobs(30, 0, 0, 3, 30);
    run(40);

    // I only, memory never answers -> watchdog completions
    set_knobs(0, 100, 255, 255, 0);
    run(45);

    // ack lands on the last watchdog cycle -> ack wins
    set_knobs(100, 0, TIMEOUT - 1, TIMEOUT - 1, 0);
    run(40);

    // mixed random traffic
    set_knobs(40, 40, 0, TIMEOUT + 1, 30);
    run(1500);

    // reset in the middle of a D grant
    set_knobs(100, 0, 10, 10, 0);
    guard = 0;
    while (!(busy && !own_i && wait_n == 2) && guard < 200) begin
      step();
      guard++;
    end
    check("find_dgrant", 32'(guard < 200), 32'd1);
    if (guard < 200) begin
      i_m_ack   = 1'b1;
      i_m_rdata = 32'h1234_5678;
      rst_n     = 1'b0;
      #1;
      check_all_zero("midrst");
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      i_m_ack = 1'b0;
      rst_n   = 1'b1;
      model_reset();
      #1;
      check("post_rst_state", o_dbg_state, 2'd0);
      step();
      check("regrant_state", o_dbg_state, 2'd1);
    end
    set_knobs(50, 50, 0, 5, 20);
    run(200);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
